// File: rtl/dvi_capture.sv
// Video sink: measures DVI frame geometry, checks active size, computes a per-frame pixel checksum.
// Latency: results latched on the clock edge that samples the next vsync assertion; no extra pipeline.
// Backpressure: none; the pixel stream is sampled every cycle and cannot be stalled.
module dvi_capture #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        ve,
    output logic        frame_done,
    output logic [11:0] meas_h_active,
    output logic [11:0] meas_v_active,
    output logic [11:0] meas_h_total,
    output logic [31:0] checksum,
    output logic [15:0] frame_count,
    output logic        err_h,
    output logic        err_v,
    output logic        locked
);

    localparam logic [11:0] H_EXP   = H_ACTIVE[11:0];
    localparam logic [11:0] V_EXP   = V_ACTIVE[11:0];
    localparam logic [11:0] CNT_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_VSYNC = 2'd1,
        CAPTURE    = 2'd2
    } state_t;

    state_t      state;
    logic        hs_q, vs_q, ve_q;
    logic [11:0] pix_cnt, line_cnt, line_w, hs_cnt, h_tot;
    logic        line_err;
    logic [31:0] chk;
    logic [1:0]  good_cnt;

    logic        hs, vs, vs_rise, hs_rise, ve_fall;
    logic [31:0] pixel, chk_step;
    logic [11:0] pix_inc, line_inc, hs_inc;
    logic [11:0] close_line_cnt, close_line_w;
    logic        close_err_h, close_err_v;

    // Sync normalisation, edge detection and the "what the frame looks like if it closes now" view.
    always_comb begin
        hs       = hsync ^ SYNC_ACTIVE_LOW;
        vs       = vsync ^ SYNC_ACTIVE_LOW;
        vs_rise  = vs & ~vs_q;
        hs_rise  = hs & ~hs_q;
        ve_fall  = ~ve & ve_q;
        pixel    = {8'h00, red, green, blue};
        chk_step = {chk[30:0], chk[31]} ^ pixel;
        pix_inc  = (pix_cnt  == CNT_MAX) ? CNT_MAX : pix_cnt + 12'd1;
        line_inc = (line_cnt == CNT_MAX) ? CNT_MAX : line_cnt + 12'd1;
        hs_inc   = (hs_cnt   == CNT_MAX) ? CNT_MAX : hs_cnt + 12'd1;
        // A line ending on the closing edge belongs to the closing frame; a line still
        // running at the close is dropped from the count but flagged as a width error.
        close_line_cnt = ve_fall ? line_inc : line_cnt;
        close_line_w   = ve_fall ? pix_cnt  : line_w;
        close_err_h    = line_err | (ve_fall & (pix_cnt != H_EXP)) | (ve_q & ve);
        close_err_v    = (close_line_cnt != V_EXP);
    end

    // Capture FSM with its accumulators and registered result outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            ve_q          <= 1'b0;
            pix_cnt       <= '0;
            line_cnt      <= '0;
            line_w        <= '0;
            line_err      <= 1'b0;
            chk           <= '0;
            hs_cnt        <= '0;
            h_tot         <= '0;
            good_cnt      <= '0;
            frame_done    <= 1'b0;
            meas_h_active <= '0;
            meas_v_active <= '0;
            meas_h_total  <= '0;
            checksum      <= '0;
            frame_count   <= '0;
            err_h         <= 1'b0;
            err_v         <= 1'b0;
            locked        <= 1'b0;
        end else begin
            hs_q       <= hs;
            vs_q       <= vs;
            ve_q       <= ve;
            frame_done <= 1'b0;
            if (!enable) begin
                // Disarm: results stay visible, but lock must be re-earned.
                state    <= IDLE;
                pix_cnt  <= '0;
                line_cnt <= '0;
                line_w   <= '0;
                line_err <= 1'b0;
                chk      <= '0;
                hs_cnt   <= '0;
                h_tot    <= '0;
                good_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= WAIT_VSYNC;
                    WAIT_VSYNC: begin
                        if (vs_rise) begin
                            state    <= CAPTURE;
                            pix_cnt  <= ve ? 12'd1 : 12'd0;
                            chk      <= ve ? pixel : 32'd0;
                            line_cnt <= '0;
                            line_w   <= '0;
                            line_err <= 1'b0;
                        end
                    end
                    CAPTURE: begin
                        if (hs_rise) begin
                            h_tot  <= hs_inc;
                            hs_cnt <= '0;
                        end else begin
                            hs_cnt <= hs_inc;
                        end
                        if (vs_rise) begin
                            meas_h_active <= close_line_w;
                            meas_v_active <= close_line_cnt;
                            meas_h_total  <= h_tot;
                            checksum      <= chk;
                            err_h         <= close_err_h;
                            err_v         <= close_err_v;
                            frame_count   <= frame_count + 16'd1;
                            frame_done    <= 1'b1;
                            if (!close_err_h && !close_err_v) begin
                                good_cnt <= (good_cnt == 2'd2) ? 2'd2 : good_cnt + 2'd1;
                                locked   <= (good_cnt >= 2'd1);
                            end else begin
                                good_cnt <= '0;
                                locked   <= 1'b0;
                            end
                            // The pixel on the closing cycle opens the new frame.
                            pix_cnt  <= ve ? 12'd1 : 12'd0;
                            chk      <= ve ? pixel : 32'd0;
                            line_cnt <= '0;
                            line_w   <= '0;
                            line_err <= 1'b0;
                        end else begin
                            if (ve) begin
                                pix_cnt <= pix_inc;
                                chk     <= chk_step;
                            end
                            if (ve_fall) begin
                                line_w   <= pix_cnt;
                                line_err <= line_err | (pix_cnt != H_EXP);
                                line_cnt <= line_inc;
                                pix_cnt  <= '0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
